// File: rtl/pooling_array_v2_if.sv
// Bundle of the start/config, pixel-stream and result signals of pooling_array_v2.
interface pooling_array_v2_if #(
  parameter int DW      = 16,
  parameter int COLS    = 32,
  parameter int MAX_WIN = 16
);
  localparam int WW = $clog2(MAX_WIN + 1);

  logic               start;
  logic               cfg_avg;
  logic               cfg_k4;
  logic [WW-1:0]      cfg_win_w;
  logic [7:0]         cfg_win_h;
  logic               in_valid;
  logic [COLS*DW-1:0] in_data;
  logic [COLS-1:0]    out_valid;
  logic [COLS*DW-1:0] out_data;
  logic               busy;
  logic               done;

  modport master (
    output start, cfg_avg, cfg_k4, cfg_win_w, cfg_win_h, in_valid, in_data,
    input  out_valid, out_data, busy, done
  );

  modport slave (
    input  start, cfg_avg, cfg_k4, cfg_win_w, cfg_win_h, in_valid, in_data,
    output out_valid, out_data, busy, done
  );
endinterface

// File: rtl/pooling_array_v2.sv
// pooling_array_v2: non-overlapping KxK (K = 2 or 4) max/average pooling over
// COLS skewed channel streams. One controller walks the window geometry and
// builds a control word that ripples one register per column to follow the
// input skew; each column keeps one running partial per window of a row.
module pooling_array_v2 #(
  parameter int DW      = 16,
  parameter int COLS    = 32,
  parameter int MAX_WIN = 16
) (
  input logic               clk,
  input logic               rst,
  pooling_array_v2_if.slave bus
);
  localparam int ACC_W = DW + 4;
  localparam int WW    = $clog2(MAX_WIN + 1);
  localparam int WCW   = (MAX_WIN > 1) ? $clog2(MAX_WIN) : 1;
  localparam int FCW   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int SK    = (COLS > 1) ? COLS - 1 : 1;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  typedef struct packed {
    logic           valid;
    logic           first;
    logic           last;
    logic [WCW-1:0] wc;
    logic           avg;
    logic           k4;
  } ctrl_t;

  state_t             state, state_next;
  logic               cfg_avg_q, cfg_k4_q;
  logic [WCW-1:0]     last_wc, last_wc_new;
  logic [7:0]         last_wr, last_wr_new;
  logic [WW-1:0]      win_w_eff;
  logic [1:0]         kc, kr, k_last;
  logic [WCW-1:0]     wc;
  logic [7:0]         wr;
  logic [FCW-1:0]     flush_cnt;
  logic               pix, final_pix;
  ctrl_t              ctrl0;
  ctrl_t              ctrl_q   [SK];
  ctrl_t              col_ctrl [COLS];
  logic [COLS-1:0]    emit;
  logic [COLS*DW-1:0] res;

  assign k_last    = cfg_k4_q ? 2'd3 : 2'd1;
  assign pix       = (state == RUN) && bus.in_valid;
  assign final_pix = pix && (kc == k_last) && (kr == k_last) &&
                     (wc == last_wc) && (wr == last_wr);

  // Normalise the requested map size: zero means one window, width clamps to the buffer depth.
  always_comb begin
    win_w_eff = bus.cfg_win_w;
    if (bus.cfg_win_w == '0)
      win_w_eff = WW'(1);
    else if (bus.cfg_win_w > WW'(MAX_WIN))
      win_w_eff = WW'(MAX_WIN);
    last_wc_new = WCW'(win_w_eff - WW'(1));
    last_wr_new = (bus.cfg_win_h == 8'd0) ? 8'd0 : bus.cfg_win_h - 8'd1;
  end

  // Next-state and handshake outputs of the map sequencer.
  always_comb begin
    state_next = state;
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    unique case (state)
      IDLE:  if (bus.start) state_next = RUN;
      RUN: begin
        bus.busy = 1'b1;
        if (final_pix) state_next = FLUSH;
      end
      FLUSH: begin
        bus.busy = 1'b1;
        if (flush_cnt == FCW'(COLS - 1)) state_next = DONE;
      end
      DONE:  begin
        bus.done   = 1'b1;
        state_next = IDLE;
      end
    endcase
  end

  // State register and configuration captured on an accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cfg_avg_q <= 1'b0;
      cfg_k4_q  <= 1'b0;
      last_wc   <= '0;
      last_wr   <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && bus.start) begin
        cfg_avg_q <= bus.cfg_avg;
        cfg_k4_q  <= bus.cfg_k4;
        last_wc   <= last_wc_new;
        last_wr   <= last_wr_new;
      end
    end
  end

  // Pixel position counters, nested kc -> wc -> kr -> wr, advancing only on accepted pixels.
  always_ff @(posedge clk) begin
    if (rst || state != RUN) begin
      kc <= '0;
      kr <= '0;
      wc <= '0;
      wr <= '0;
    end else if (pix) begin
      if (kc == k_last) begin
        kc <= '0;
        if (wc == last_wc) begin
          wc <= '0;
          if (kr == k_last) begin
            kr <= '0;
            wr <= wr + 8'd1;
          end else begin
            kr <= kr + 2'd1;
          end
        end else begin
          wc <= wc + WCW'(1);
        end
      end else begin
        kc <= kc + 2'd1;
      end
    end
  end

  // Flush counter lets the last column drain before done.
  always_ff @(posedge clk) begin
    if (rst || state != FLUSH) flush_cnt <= '0;
    else                       flush_cnt <= flush_cnt + FCW'(1);
  end

  // Control word seen by column 0 in the pixel's own cycle.
  always_comb begin
    ctrl0       = '0;
    ctrl0.valid = pix;
    ctrl0.first = (kr == 2'd0) && (kc == 2'd0);
    ctrl0.last  = (kr == k_last) && (kc == k_last);
    ctrl0.wc    = wc;
    ctrl0.avg   = cfg_avg_q;
    ctrl0.k4    = cfg_k4_q;
  end

  // Skew chain: column j sees the control word j cycles late, matching its data.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SK; i++) ctrl_q[i] <= '0;
    end else begin
      ctrl_q[0] <= ctrl0;
      for (int i = 1; i < SK; i++) ctrl_q[i] <= ctrl_q[i-1];
    end
  end

  // Select each column's control word from the skew chain.
  always_comb begin
    col_ctrl[0] = ctrl0;
    for (int j = 1; j < COLS; j++) col_ctrl[j] = ctrl_q[j-1];
  end

  for (genvar j = 0; j < COLS; j++) begin : g_col
    logic signed [DW-1:0]    sample;
    logic signed [ACC_W-1:0] sample_ext, acc_in, nxt;
    logic signed [ACC_W-1:0] part_buf [MAX_WIN];
    logic [DW-1:0]           scaled;
    ctrl_t                   c;

    assign c          = col_ctrl[j];
    assign sample     = bus.in_data[j*DW +: DW];
    assign sample_ext = {{(ACC_W-DW){sample[DW-1]}}, sample};

    // Fold the sample into the window partial; first pixel of a window restarts it.
    always_comb begin
      acc_in = c.first ? sample_ext : part_buf[c.wc];
      if (c.avg) nxt = c.first ? acc_in : acc_in + sample_ext;
      else       nxt = (c.first || sample_ext > acc_in) ? sample_ext : acc_in;
      if (c.avg) scaled = DW'(c.k4 ? (nxt >>> 4) : (nxt >>> 2));
      else       scaled = DW'(nxt);
    end

    // Every valid pixel refreshes its window's partial entry.
    always_ff @(posedge clk) begin
      if (c.valid) part_buf[c.wc] <= nxt;
    end

    assign emit[j]         = c.valid & c.last;
    assign res[j*DW +: DW] = scaled;
  end

  // Register finished window results; data holds between strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= '0;
      bus.out_data  <= '0;
    end else begin
      bus.out_valid <= emit;
      for (int j = 0; j < COLS; j++)
        if (emit[j]) bus.out_data[j*DW +: DW] <= res[j*DW +: DW];
    end
  end
endmodule

// File: doc/pooling_array_v2.md
Name: pooling_array_v2

Overview:
- Parametrised successor to the fixed 32-column pooling unit. Performs non-overlapping KxK max or average pooling on COLS independent channel streams coming from the systolic array.
- One shared controller generates window and line-buffer control. That control is delayed one register stage per column to match the systolic output skew.
- Compared with the previous unit, it adds runtime window size (2 or 4), runtime feature-map dimensions, per-column partial-row buffers, in_valid gaps, and a done/busy handshake.

Parameters:
DW, 16, signed data width of each column sample
COLS, 32, number of pooling columns (>=1)
MAX_WIN, 16, max pooling windows per feature-map row; sizes the per-column partial buffer
ACC_W, DW+4, accumulator width (fixed derivation, not user-set)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
start  in  1  one-cycle pulse; latches cfg_* and begins a map
cfg_avg  in  1  0 = max pooling, 1 = average pooling
cfg_k4  in  1  0 = 2x2 window, 1 = 4x4 window
cfg_win_w  in  $clog2(MAX_WIN+1)  windows per row; 0 treated as 1; values >MAX_WIN clamp to MAX_WIN
cfg_win_h  in  8  windows per column of map; 0 treated as 1
in_valid  in  1  column-0 pixel valid; column j samples its data j cycles later
in_data  in  COLS*DW  column j at bits [j*DW +: DW], two's complement
out_valid  out  COLS  per-column result strobe, skewed like the inputs
out_data  out  COLS*DW  per-column pooled result
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse when the last column has emitted its last result

Behaviour:
- Reset (rst=1 at clk edge): FSM->IDLE; all counters 0; out_valid=0; out_data=0; busy=0; done=0; skew registers cleared. Partial-buffer contents are don't-care, because every window's first pixel overwrites its entry.
- Derived sizes: K = cfg_k4 ? 4 : 2. Map is (win_w*K) pixels wide by (win_h*K) rows, streamed row-major. One pixel per in_valid cycle. Gaps in in_valid are allowed; counters advance only on in_valid.
- FSM states:
  - IDLE: on start, latch cfg, go to RUN, busy=1. in_valid in IDLE is ignored.
  - RUN: counters advance per in_valid:
    - kc (column within window, 0..K-1)
    - wc (window column, 0..win_w-1)
    - kr (row within window, 0..K-1)
    - wr (window row, 0..win_h-1)
    - On the final pixel (all counters at max), go to FLUSH.
  - FLUSH: count COLS cycles, then go to DONE.
  - DONE: done=1 for one cycle, busy=0, go to IDLE.
- start while not IDLE is ignored. cfg changes after start have no effect until the next start.
- Control word per pixel: {valid, first = (kr==0 && kc==0), last = (kr==K-1 && kc==K-1), wc, avg, k4}.
  - Column 0 uses it in the same cycle.
  - Column j uses the copy delayed j registers.
- Per-column datapath, on a valid control word:
  - Operand: acc_in = first ? in_sample(sign-extended to ACC_W) : buf[wc].
  - Max mode: new = first ? sample : signed max(buf[wc], sample).
  - Avg mode: new = acc_in (+ sample unless first).
  - Write new to buf[wc] every valid cycle.
  - If last: register the result next cycle, out_valid[j]=1 for exactly one cycle.
    - Max mode: result is new[DW-1:0].
    - Avg mode: result is new >>> (k4 ? 4 : 2), arithmetic shift (floor toward -inf), truncated to DW.
  - No saturation is needed: ACC_W=DW+4 holds 16 samples.
- Latency: column j out_valid rises j+1 cycles after column 0 receives the window's last pixel (bottom-right).
- Result order per column: row-major over windows, win_w*win_h results per map.
- done rises exactly COLS+1 cycles after the final in_valid (FLUSH COLS cycles, then DONE), i.e. the cycle after column COLS-1 emits.
- rst mid-map: everything returns to reset values the next cycle, and in-flight results are discarded with no out_valid. A new start is accepted immediately after.
- Back-to-back maps: start is accepted only in IDLE, so at least 1 idle cycle separates done and the next start.

Test Plan:
1. COLS=4, 2x2 max, win_w=2, win_h=2; column 0 ramp 0..15 row-major. Expect col0 results 5, 7, 13, 15. Expect col3 identical results delayed 3 cycles. done 5 cycles after pixel 15.
2. 2x2 avg on window {-1,-2,-3,-4} -> sum -10, >>>2 = -3 (floor). Window {1,2,3,5} -> 2.
3. 4x4 avg, win_w=1, win_h=1, all samples 0x7FFF -> 0x7FFF (no overflow). 4x4 max with one sample -32768 and the rest -5 -> -5.
4. win_w=MAX_WIN, in_valid deasserted every 3rd cycle. Expect the same results as the gapless run, with out_valid spacing tracking the gaps.
5. Assert rst after 7 pixels of a map. Expect out_valid=0, busy=0 next cycle. Run a fresh map: results correct, with no contamination from stale buf.
6. Pulse start while busy with different cfg. Expect it ignored: results follow the original cfg. cfg_win_w=0 -> behaves as 1.
